// File: rtl/vga_timing_gen.sv
// VGA/DVI raster timing generator running directly on the 100 MHz board clock.
// A clock divider produces a one-cycle pixel enable; all raster outputs are registered on it.
module vga_timing_gen #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          H_POL    = 1'b0,
   parameter bit          V_POL    = 1'b0,
   parameter int unsigned CW       = 12
) (
   input  logic          real100clock,
   input  logic          reset,
   output logic          pix_ce,
   output logic          VGAclock,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic [CW-1:0] x_pos,
   output logic [CW-1:0] y_pos,
   output logic          line_start,
   output logic          frame_start
);

   localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned HS_START  = H_ACTIVE + H_FP;
   localparam int unsigned HS_END    = H_ACTIVE + H_FP + H_SYNC;
   localparam int unsigned VS_START  = V_ACTIVE + V_FP;
   localparam int unsigned VS_END    = V_ACTIVE + V_FP + V_SYNC;

   // Reject parameter sets that cannot produce a legal raster.
   if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be even and >= 2");
   end
   if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
      $error("vga_timing_gen: active, porch and sync values must be non-zero");
   end
   if ((64'(1) << CW) < 64'(H_TOTAL) || (64'(1) << CW) < 64'(V_TOTAL)) begin : g_bad_cw
      $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
   end

   logic [DW-1:0] div_q, div_d;
   logic [CW-1:0] h_q, h_d;
   logic [CW-1:0] v_q, v_d;
   logic [CW-1:0] x_q, x_d;
   logic [CW-1:0] y_q, y_d;
   logic          vga_clk_q, vga_clk_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          de_q, de_d;
   logic          line_q, line_d;
   logic          frame_q, frame_d;

   assign pix_ce      = (div_q == DW'(CLK_DIV - 1));
   assign VGAclock    = vga_clk_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign x_pos       = x_q;
   assign y_pos       = y_q;
   assign line_start  = line_q;
   assign frame_start = frame_q;

   // Next-state: divider, raster counters, and decode of the new position on pix_ce.
   always_comb begin
      div_d   = div_q + DW'(1);
      h_d     = h_q;
      v_d     = v_q;
      x_d     = x_q;
      y_d     = y_q;
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      de_d    = de_q;
      line_d  = line_q;
      frame_d = frame_q;

      if (pix_ce) begin
         div_d = '0;
         if (h_q >= CW'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q >= CW'(V_TOTAL - 1)) ? '0 : v_q + CW'(1);
         end else begin
            h_d = h_q + CW'(1);
         end

         x_d     = h_d;
         y_d     = v_d;
         de_d    = (h_d < CW'(H_ACTIVE)) && (v_d < CW'(V_ACTIVE));
         hsync_d = ((h_d >= CW'(HS_START)) && (h_d < CW'(HS_END))) ? H_POL : !H_POL;
         vsync_d = ((v_d >= CW'(VS_START)) && (v_d < CW'(VS_END))) ? V_POL : !V_POL;
         line_d  = (h_d == '0);
         frame_d = (h_d == '0) && (v_d == '0);
      end

      // High in the second half of each pixel period so the DAC samples mid-pixel.
      vga_clk_d = (div_d >= DW'(CLK_DIV / 2));
   end

   always_ff @(posedge real100clock) begin
      if (reset) begin
         div_q     <= '0;
         h_q       <= CW'(H_TOTAL - 1);
         v_q       <= CW'(V_TOTAL - 1);
         x_q       <= '0;
         y_q       <= '0;
         vga_clk_q <= 1'b0;
         hsync_q   <= !H_POL;
         vsync_q   <= !V_POL;
         de_q      <= 1'b0;
         line_q    <= 1'b0;
         frame_q   <= 1'b0;
      end else begin
         div_q     <= div_d;
         h_q       <= h_d;
         v_q       <= v_d;
         x_q       <= x_d;
         y_q       <= y_d;
         vga_clk_q <= vga_clk_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         de_q      <= de_d;
         line_q    <= line_d;
         frame_q   <= frame_d;
      end
   end

endmodule
